// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64 instruction fetch stage: owns the PC, issues one
// outstanding imem request at a time and holds the fetched word for decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [63:0] target;

  // Low two bits of the redirect target are forced to zero (word alignment).
  assign target = redirect_pc & ~64'h3;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = target;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = target;
        // An accepted request that coincides with a redirect is already stale.
        if (imem_req_ready) state_d = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          if_instr_d = imem_resp_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 64'd4;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect flushes the held instruction even when decode is ready.
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = S_REQ;
        end else if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = target;
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 64'h0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - bench for fetch_unit: memory model with variable
// latency plus a PC-stream scoreboard for what reaches decode.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready = 1'b1;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .id_ready        (id_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  int          mem_lat;
  bit          mem_rand_ready;
  logic [63:0] exp_next;
  logic [63:0] acc_q[$];
  logic [63:0] del_pc_q[$];
  int          del_cyc_q[$];

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    id_ready = 1'b1;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    mem_busy = 1'b0;
    mem_cnt = 0;
    mem_lat = 1;
    mem_rand_ready = 1'b0;
    exp_next = RST_PC;
    acc_q.delete();
    del_pc_q.delete();
    del_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
  endtask

  // One clock: memory drives its inputs, handshakes are captured, then the
  // scoreboard is updated with what the edge committed.
  task automatic cycle();
    logic        pre_acc, pre_resp, pre_cons, pre_redir, pre_hold, pre_ifv;
    logic [63:0] pre_addr, pre_rpc, pre_ifpc;
    logic [31:0] pre_instr;
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? mem_fn(mem_addr) : 32'hDEAD_BEEF;
    imem_req_ready  = mem_rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    n_checks++;
    if (imem_req_valid === 1'b1 && mem_busy) begin
      n_fail++;
      $display("FAIL outstanding: req_valid=1 addr=%h while a request is still outstanding", imem_req_addr);
    end
    pre_acc   = (imem_req_valid === 1'b1) && imem_req_ready;
    pre_addr  = imem_req_addr;
    pre_resp  = imem_resp_valid;
    pre_cons  = (if_valid === 1'b1) && id_ready;
    pre_redir = redirect_valid;
    pre_rpc   = {redirect_pc[63:2], 2'b00};
    pre_ifv   = (if_valid === 1'b1);
    pre_hold  = (if_valid === 1'b1) && !id_ready && !redirect_valid;
    pre_ifpc  = if_pc;
    pre_instr = if_instr;
    if (pre_acc) begin
      n_checks++;
      if (pre_addr[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL req_align: addr=%h required low bits 00", pre_addr);
      end
      acc_q.push_back(pre_addr);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pre_resp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (pre_acc) begin
      mem_busy = 1'b1;
      mem_addr = pre_addr;
      mem_cnt  = ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat) - 1;
    end
    if (pre_redir) exp_next = pre_rpc;
    else if (pre_cons) exp_next = pre_ifpc + 64'd4;
    if (pre_hold) begin
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== pre_ifpc || if_instr !== pre_instr) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 if_valid, if_pc, if_instr, pre_ifpc, pre_instr);
      end
    end
    if (!pre_ifv && if_valid === 1'b1) begin
      n_checks++;
      if (if_pc !== exp_next || if_instr !== mem_fn(exp_next)) begin
        n_fail++;
        $display("FAIL delivery: got pc=%h instr=%h required pc=%h instr=%h",
                 if_pc, if_instr, exp_next, mem_fn(exp_next));
      end
      del_pc_q.push_back(if_pc);
      del_cyc_q.push_back(cyc);
    end
  endtask

  task automatic redir_cycle(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    mem_busy = 1'b0;
    mem_lat = 1;
    mem_rand_ready = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_req: got v=%b addr=%h required v=0 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    n_checks++;
    if (if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_if: got v=%b pc=%h instr=%h required 0 0 0", if_valid, if_pc, if_instr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    exp_next = RST_PC;
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle_req: got %b required 0", imem_req_valid);
    end
    cycle();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL second_cycle_req: got v=%b addr=%h required v=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_a;
    do_reset();
    for (int k = 0; k < 60 && del_pc_q.size() < 3; k++) cycle();
    n_checks++;
    if (del_pc_q.size() < 3) begin
      n_fail++;
      $display("FAIL seq_timeout: got %0d deliveries required 3", del_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_a = 64'h1000 + 64'(4 * i);
        n_checks++;
        if (acc_q[i] !== exp_a || del_pc_q[i] !== exp_a) begin
          n_fail++;
          $display("FAIL seq_addr%0d: got req=%h if_pc=%h required %h", i, acc_q[i], del_pc_q[i], exp_a);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (del_cyc_q[i] - del_cyc_q[i-1] != 3) begin
          n_fail++;
          $display("FAIL seq_rate%0d: got %0d cycles required 3", i, del_cyc_q[i] - del_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 60 && !(if_valid === 1'b1 && if_pc === 64'h1004); k++) cycle();
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 64'h1004 || if_instr !== mem_fn(64'h1004) || imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: got v=%b pc=%h instr=%h req=%b required v=1 pc=1004 instr=%h req=0",
                 i, if_valid, if_pc, if_instr, imem_req_valid, mem_fn(64'h1004));
      end
    end
    id_ready = 1'b1;
    acc_q.delete();
    for (int k = 0; k < 20 && acc_q.size() < 1; k++) cycle();
    n_checks++;
    if (acc_q.size() < 1 || acc_q[0] !== 64'h1008) begin
      n_fail++;
      $display("FAIL stall_release: got %0d reqs first=%h required 1008", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hX);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 4;
    for (int k = 0; k < 20 && acc_q.size() < 1; k++) cycle();
    redir_cycle(64'h2002);
    acc_q.delete();
    del_pc_q.delete();
    for (int k = 0; k < 40 && del_pc_q.size() < 1; k++) cycle();
    n_checks++;
    if (acc_q.size() < 1 || acc_q[0] !== 64'h2000 || del_pc_q.size() < 1 || del_pc_q[0] !== 64'h2000) begin
      n_fail++;
      $display("FAIL redirect_wait: got req=%h if_pc=%h required 2000 2000",
               (acc_q.size() > 0) ? acc_q[0] : 64'hX, (del_pc_q.size() > 0) ? del_pc_q[0] : 64'hX);
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    for (int k = 0; k < 20 && acc_q.size() < 1; k++) cycle();
    redir_cycle(64'h3000);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_resp: got req=%b addr=%h if_valid=%b required 1 3000 0", imem_req_valid, imem_req_addr, if_valid);
    end
    del_pc_q.delete();
    for (int k = 0; k < 20 && del_pc_q.size() < 1; k++) cycle();
    n_checks++;
    if (del_pc_q.size() < 1 || del_pc_q[0] !== 64'h3000) begin
      n_fail++;
      $display("FAIL redirect_resp_deliver: got %h required 3000", (del_pc_q.size() > 0) ? del_pc_q[0] : 64'hX);
    end
    do_reset();
    for (int k = 0; k < 10 && imem_req_valid !== 1'b1; k++) cycle();
    redir_cycle(64'h4000);
    n_checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_req_drop: got req=%b if_valid=%b required 0 0", imem_req_valid, if_valid);
    end
    cycle();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4000) begin
      n_fail++;
      $display("FAIL redirect_req_target: got req=%b addr=%h required 1 4000", imem_req_valid, imem_req_addr);
    end
    del_pc_q.delete();
    for (int k = 0; k < 20 && del_pc_q.size() < 1; k++) cycle();
    n_checks++;
    if (del_pc_q.size() < 1 || del_pc_q[0] !== 64'h4000) begin
      n_fail++;
      $display("FAIL redirect_req_deliver: got %h required 4000", (del_pc_q.size() > 0) ? del_pc_q[0] : 64'hX);
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    for (int k = 0; k < 20 && if_valid !== 1'b1; k++) cycle();
    id_ready = 1'b1;
    redir_cycle(64'h5000);
    n_checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h5000) begin
      n_fail++;
      $display("FAIL hold_redirect: got if_valid=%b req=%b addr=%h required 0 1 5000", if_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redir_cycle(64'hFFFF_FFFF_FFFF_FFFC);
    for (int k = 0; k < 30 && acc_q.size() < 2; k++) cycle();
    n_checks++;
    if (acc_q.size() < 2 || acc_q[0] !== 64'hFFFF_FFFF_FFFF_FFFC || acc_q[1] !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap: got %0d reqs first=%h second=%h required FFFFFFFFFFFFFFFC then 0",
               acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 64'hX, (acc_q.size() > 1) ? acc_q[1] : 64'hX);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 4;
    for (int k = 0; k < 40 && acc_q.size() < 2; k++) cycle();
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got req=%b addr=%h v=%b pc=%h instr=%h required 0 %h 0 0 0",
               imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, RST_PC);
    end
  endtask

  task automatic test_random();
    logic [63:0] t;
    do_reset();
    mem_lat = 0;
    mem_rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        t = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        redirect_valid = 1'b1;
        redirect_pc = t;
      end else begin
        redirect_valid = 1'b0;
      end
      cycle();
    end
    redirect_valid = 1'b0;
    n_checks++;
    if (del_pc_q.size() < 20) begin
      n_fail++;
      $display("FAIL random_progress: got %0d deliveries required at least 20", del_pc_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_hold_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
